tmc4671_poller: RTL



---
 rtl/tmc4671_pkg.sv | 24 ++
 rtl/tmc4671_poller_if.sv | 20 ++
 rtl/tmc4671_tick_gen.sv | 22 ++
 rtl/tmc4671_poller.sv | 126 ++++++++++++
 4 files changed

// File: rtl/tmc4671_pkg.sv
// Shared TMC4671 register map and poller state encoding.
// Pure declarations: no latency, no flow control.
package tmc4671_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_GAP,
        S_WAIT_TICK,
        S_WR_TARGET,
        S_RD_POS,
        S_RD_VEL,
        S_DONE
    } poll_state_t;

    localparam logic [6:0] TMC_ADDR_SELECT  = 7'h7F;
    localparam logic [6:0] TMC_ADDR_TARGET  = 7'h68;
    localparam logic [6:0] TMC_ADDR_ACT_VEL = 7'h6A;
    localparam logic [6:0] TMC_ADDR_ACT_POS = 7'h6B;

    function automatic logic is_xfer(input poll_state_t s);
        return s inside {S_INIT, S_WR_TARGET, S_RD_POS, S_RD_VEL};
    endfunction

endpackage

// File: rtl/tmc4671_poller_if.sv
// Avalon-MM link between the poller (master) and the TMC4671 SPI bridge (slave).
// Wires only; waitrequest is the slave's backpressure.
interface tmc4671_poller_if;
    logic [6:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/tmc4671_tick_gen.sv
// Free-running down-counter; tick is high for one cycle every PERIOD cycles.
// Tick follows the counter register combinationally; it has no backpressure.
module tmc4671_tick_gen #(
    parameter int PERIOD = 5000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int              CW     = $clog2(PERIOD);
    localparam logic [CW-1:0]   RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          cnt <= RELOAD;
        else if (cnt == '0)    cnt <= RELOAD;
        else                   cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/tmc4671_poller.sv
// Periodic TMC4671 target write / position (+velocity with TMC4671_POLL_VEL_EN) readback master.
// Tick to sample_valid: 7 cycles (5 without velocity) plus waitrequest stall cycles; stalls hold the bus.
module tmc4671_poller
    import tmc4671_pkg::*;
#(
    parameter int         CLOCK_FREQ_HZ = 50_000_000,
    parameter int         POLL_FREQ_HZ  = 10_000,
    parameter logic [6:0] ADDR_TARGET   = TMC_ADDR_TARGET,
    parameter logic [6:0] ADDR_ACT_POS  = TMC_ADDR_ACT_POS,
    parameter logic [6:0] ADDR_ACT_VEL  = TMC_ADDR_ACT_VEL,
    parameter logic       SELECT_VALUE  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [31:0]              target_pos,
    output logic [31:0]              actual_pos,
    output logic [31:0]              actual_vel,
    output logic                     sample_valid,
    output logic [15:0]              overrun_count,
    tmc4671_poller_if.master         avm
);
    localparam int PERIOD = CLOCK_FREQ_HZ / POLL_FREQ_HZ;

    logic        tick;
    poll_state_t state, state_nxt, after_gap, after_gap_nxt;
    logic        busy, accept, launch;
    logic [6:0]  launch_addr;
    logic [31:0] launch_data;
    logic [31:0] shadow_pos;

    tmc4671_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign busy   = avm.avm_read | avm.avm_write;
    assign accept = busy & ~avm.avm_waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            after_gap <= S_WAIT_TICK;
        end else begin
            state     <= state_nxt;
            after_gap <= after_gap_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        after_gap_nxt = after_gap;
        launch_addr   = avm.avm_address;
        launch_data   = avm.avm_writedata;
        case (state)
            S_INIT:      if (accept) begin state_nxt = S_GAP; after_gap_nxt = S_WAIT_TICK; end
            S_GAP:       state_nxt = after_gap;
            S_WAIT_TICK: if (tick && enable) state_nxt = S_WR_TARGET;
            S_WR_TARGET: if (accept) begin state_nxt = S_GAP; after_gap_nxt = S_RD_POS; end
            S_RD_POS: if (accept) begin
                state_nxt = S_GAP;
`ifdef TMC4671_POLL_VEL_EN
                after_gap_nxt = S_RD_VEL;
`else
                after_gap_nxt = S_DONE;
`endif
            end
            S_RD_VEL:    if (accept) begin state_nxt = S_GAP; after_gap_nxt = S_DONE; end
            S_DONE:      state_nxt = S_WAIT_TICK;
            default:     state_nxt = S_INIT;
        endcase

        // A transfer is launched only from an idle bus, so the slave always sees a fresh rising edge.
        launch = is_xfer(state_nxt) && !busy;
        case (state_nxt)
            S_INIT:      begin launch_addr = TMC_ADDR_SELECT; launch_data = {31'd0, SELECT_VALUE}; end
            S_WR_TARGET: begin launch_addr = ADDR_TARGET;     launch_data = target_pos;             end
            S_RD_POS:    launch_addr = ADDR_ACT_POS;
            S_RD_VEL:    launch_addr = ADDR_ACT_VEL;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_address   <= '0;
            avm.avm_writedata <= '0;
            shadow_pos        <= '0;
            actual_pos        <= '0;
            sample_valid      <= 1'b0;
            overrun_count     <= '0;
        end else begin
            avm.avm_read  <= (state_nxt == S_RD_POS) || (state_nxt == S_RD_VEL);
            avm.avm_write <= (state_nxt == S_INIT)   || (state_nxt == S_WR_TARGET);
            if (launch) begin
                avm.avm_address   <= launch_addr;
                avm.avm_writedata <= launch_data;
            end
            if (accept && state == S_RD_POS) shadow_pos <= avm.avm_readdata;
            sample_valid <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE) actual_pos <= shadow_pos;
            if (tick && state != S_WAIT_TICK && overrun_count != 16'hFFFF)
                overrun_count <= overrun_count + 16'd1;
        end
    end

`ifdef TMC4671_POLL_VEL_EN
    logic [31:0] shadow_vel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_vel <= '0;
            actual_vel <= '0;
        end else begin
            if (accept && state == S_RD_VEL) shadow_vel <= avm.avm_readdata;
            if (state_nxt == S_DONE) actual_vel <= shadow_vel;
        end
    end
`else
    assign actual_vel = 32'd0;
`endif

endmodule
